thread_scheduler: RTL and testbench
===================================

// Module: thread_scheduler
// PURPOSE
//  Barrel-thread issue scheduler for the multithreaded RV32I core. Each cycle it
//  emits the hardware-thread ID owning the fetch slot, in strict round-robin. It
//  gates each slot with that thread's run state, and flags a thread's first
//  issue after (re)start so fetch loads STARTUP_ADDR. Host start/halt commands
//  arrive over a valid/ready port. Halts complete only after the pipeline has
//  drained the thread.
// PARAMETERS
//  NUM_THREADS      `NUM_THREADS      hardware threads (>=2, any integer, not only pow2)
//  NUM_PIPE_STAGES  `NUM_PIPE_STAGES  pipeline depth; sets halt drain time (>=4)
//  RESET_RUN_MASK   '1                per-thread run state loaded at reset
//  TID_WIDTH        $clog2(NUM_THREADS) derived; do not override
// PORTS
//  clk            in   1            core clock
//  reset          in   1            synchronous, active-high reset
//  ctrl_valid     in   1            host command valid
//  ctrl_ready     out  1            scheduler accepts command
//  ctrl_op        in   1            0 = START, 1 = HALT
//  ctrl_tid       in   TID_WIDTH    target thread
//  ctrl_done      out  1            1-cycle pulse: accepted command complete
//  self_halt      in   1            writeback retires halt instr (ebreak)
//  self_halt_tid  in   TID_WIDTH    thread retiring it
//  issue_tid      out  TID_WIDTH    thread owning this fetch slot
//  issue_valid    out  1            slot carries a live instruction
//  issue_restart  out  1            fetch uses STARTUP_ADDR for this thread
//  running_mask   out  NUM_THREADS  current run state per thread
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: slot counter=0; running=RESET_RUN_MASK; restart_pend=RESET_RUN_MASK;
//   FSM=IDLE. Registered outputs while reset high:
//   issue_tid=0, issue_valid=0, issue_restart=0, ctrl_ready=0, ctrl_done=0.
//  Slot counter: +1 every cycle; wraps NUM_THREADS-1 -> 0; never stalls.
//   All issue_* outputs are registered.
//  Issue: at each edge, issue_tid<=cnt; issue_valid<=running[cnt] (pre-edge);
//   issue_restart<=running[cnt]&restart_pend[cnt].
//   A valid issue clears restart_pend[cnt].
//   First cycle after reset release: tid=0, valid=restart=RESET_RUN_MASK[0].
//  FSM: IDLE (ready=1) / DRAIN / DONE. Accept when ctrl_valid&&ctrl_ready.
//   START: running[tid]<=1; restart_pend[tid]<=1 unless already running
//    (no-op). Then -> DONE.
//   HALT on running thread: running[tid]<=0; drain_cnt<=NUM_PIPE_STAGES-1;
//    -> DRAIN. HALT on idle thread: -> DONE.
//   DRAIN: decrement drain_cnt each cycle; at 0 -> DONE.
//   DONE: ctrl_done=1 for exactly one cycle; -> IDLE.
//   ctrl_ready=0 in DRAIN and DONE.
//   Latency, acceptance edge E to ctrl_done high: START = E+1;
//    HALT(running) = E+NUM_PIPE_STAGES+1.
//   Run-state change applies to slots issued from edge E+1 on.
//  self_halt: clears running[self_halt_tid] at next edge. No done pulse.
//   Drain by self_halt is the writer's concern.
//  Same-edge conflicts: ctrl START and self_halt on the same tid -> START wins
//   (thread restarts with restart flag). ctrl HALT and self_halt on the same
//   tid -> normal HALT drain. Different tids -> both apply.
//  Reset asserted mid-DRAIN or DONE: abort. No ctrl_done pulse. Full reset state.
//  ctrl_tid >= NUM_THREADS: command accepted, no state change, DONE next cycle.
// TESTING
//  T1 Reset, NUM_THREADS=4, mask=4'hF: issue_tid 0,1,2,3,0,...; all valid;
//     issue_restart=1 only in first round.
//  T2 NUM_PIPE_STAGES=4, HALT tid 2 accepted at edge E: ctrl_ready low;
//     ctrl_done at E+5; tid 2 slots valid=0 from E+1 on; mask=4'hB.
//  T3 Then START tid 2: ctrl_done at E+1; tid 2's next slot has valid=1 and
//     restart=1; its following slot has restart=0.
//  T4 Same edge: self_halt tid 1 and ctrl START tid 1 -> running_mask[1]=1;
//     next tid 1 slot has restart=1.
//  T5 Reset asserted 2 cycles into HALT drain: no ctrl_done; after release
//     running_mask=RESET_RUN_MASK and issue_tid restarts at 0.
//  T6 NUM_THREADS=5: issue_tid sequence 3,4,0,1 (wrap); HALT of idle tid
//     -> ctrl_done 1 cycle after acceptance.

Source files
------------

// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : thread_scheduler
//  Purpose  : Round-robin barrel-thread issue slot generator with host
//             start/halt control and a pipeline drain before a halt completes.
//  Revision : 1.0  initial release
// ============================================================================
module thread_scheduler #(
    parameter int                     NUM_THREADS     = 4,
    parameter int                     NUM_PIPE_STAGES = 4,
    parameter logic [NUM_THREADS-1:0] RESET_RUN_MASK  = '1,
    parameter int                     TID_WIDTH       = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ctrl_valid,
    output logic                   ctrl_ready,
    input  logic                   ctrl_op,
    input  logic [TID_WIDTH-1:0]   ctrl_tid,
    output logic                   ctrl_done,
    input  logic                   self_halt,
    input  logic [TID_WIDTH-1:0]   self_halt_tid,
    output logic [TID_WIDTH-1:0]   issue_tid,
    output logic                   issue_valid,
    output logic                   issue_restart,
    output logic [NUM_THREADS-1:0] running_mask
);

    localparam int                    DRAIN_W     = $clog2(NUM_PIPE_STAGES);
    localparam int                    TID_SPACE   = 1 << TID_WIDTH;
    localparam logic [TID_WIDTH-1:0]  LAST_TID    = TID_WIDTH'(NUM_THREADS - 1);
    localparam logic [DRAIN_W-1:0]    DRAIN_INIT  = DRAIN_W'(NUM_PIPE_STAGES - 1);
    localparam logic [TID_SPACE-1:0]  TID_OK_MASK = TID_SPACE'((65'(1) << NUM_THREADS) - 65'(1));
    localparam logic                  OP_START    = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TID_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_THREADS-1:0] running_q, running_d;
    logic [NUM_THREADS-1:0] restart_pend_q, restart_pend_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic [TID_WIDTH-1:0]   issue_tid_q, issue_tid_d;
    logic                   issue_valid_q, issue_valid_d;
    logic                   issue_restart_q, issue_restart_d;
    logic                   ctrl_ready_q, ctrl_ready_d;
    logic                   ctrl_done_q, ctrl_done_d;
    logic                   accept;
    logic                   ctrl_tid_ok;
    logic                   self_tid_ok;

    always_comb begin
        accept      = ctrl_valid && ctrl_ready_q;
        ctrl_tid_ok = TID_OK_MASK[ctrl_tid];
        self_tid_ok = TID_OK_MASK[self_halt_tid];

        cnt_d           = (cnt_q == LAST_TID) ? '0 : cnt_q + TID_WIDTH'(1);
        issue_tid_d     = cnt_q;
        issue_valid_d   = running_q[cnt_q];
        issue_restart_d = running_q[cnt_q] & restart_pend_q[cnt_q];

        running_d      = running_q;
        restart_pend_d = restart_pend_q;
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;

        if (issue_valid_d) begin
            restart_pend_d[cnt_q] = 1'b0;
        end
        // Self-halt is applied before host commands so a same-tid START wins.
        if (self_halt && self_tid_ok) begin
            running_d[self_halt_tid] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DONE;
                    if (ctrl_tid_ok) begin
                        if (ctrl_op == OP_START) begin
                            if (!running_d[ctrl_tid]) begin
                                restart_pend_d[ctrl_tid] = 1'b1;
                            end
                            running_d[ctrl_tid] = 1'b1;
                        end else if (running_q[ctrl_tid]) begin
                            running_d[ctrl_tid] = 1'b0;
                            drain_cnt_d         = DRAIN_INIT;
                            state_d             = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ctrl_ready_d = (state_d == ST_IDLE);
        ctrl_done_d  = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            running_q       <= RESET_RUN_MASK;
            restart_pend_q  <= RESET_RUN_MASK;
            drain_cnt_q     <= '0;
            issue_tid_q     <= '0;
            issue_valid_q   <= 1'b0;
            issue_restart_q <= 1'b0;
            ctrl_ready_q    <= 1'b0;
            ctrl_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            running_q       <= running_d;
            restart_pend_q  <= restart_pend_d;
            drain_cnt_q     <= drain_cnt_d;
            issue_tid_q     <= issue_tid_d;
            issue_valid_q   <= issue_valid_d;
            issue_restart_q <= issue_restart_d;
            ctrl_ready_q    <= ctrl_ready_d;
            ctrl_done_q     <= ctrl_done_d;
        end
    end

    assign issue_tid     = issue_tid_q;
    assign issue_valid   = issue_valid_q;
    assign issue_restart = issue_restart_q;
    assign ctrl_ready    = ctrl_ready_q;
    assign ctrl_done     = ctrl_done_q;
    assign running_mask  = running_q;

endmodule
`default_nettype wire

// File: tb/tb_thread_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_thread_scheduler
//  Purpose  : Directed bench for thread_scheduler (4-thread and 5-thread builds)
//             with an issue-slot scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_thread_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_ctrl_valid, a_ctrl_ready, a_ctrl_op, a_ctrl_done;
    logic [1:0] a_ctrl_tid, a_self_halt_tid, a_issue_tid;
    logic       a_self_halt, a_issue_valid, a_issue_restart;
    logic [3:0] a_running_mask;

    logic       b_ctrl_valid, b_ctrl_ready, b_ctrl_op, b_ctrl_done;
    logic [2:0] b_ctrl_tid, b_self_halt_tid, b_issue_tid;
    logic       b_self_halt, b_issue_valid, b_issue_restart;
    logic [4:0] b_running_mask;

    thread_scheduler #(.NUM_THREADS(4), .NUM_PIPE_STAGES(4), .RESET_RUN_MASK(4'hF)) u_dut_a (
        .clk(clk), .reset(reset),
        .ctrl_valid(a_ctrl_valid), .ctrl_ready(a_ctrl_ready), .ctrl_op(a_ctrl_op),
        .ctrl_tid(a_ctrl_tid), .ctrl_done(a_ctrl_done),
        .self_halt(a_self_halt), .self_halt_tid(a_self_halt_tid),
        .issue_tid(a_issue_tid), .issue_valid(a_issue_valid),
        .issue_restart(a_issue_restart), .running_mask(a_running_mask)
    );

    thread_scheduler #(.NUM_THREADS(5), .NUM_PIPE_STAGES(4), .RESET_RUN_MASK(5'h1F)) u_dut_b (
        .clk(clk), .reset(reset),
        .ctrl_valid(b_ctrl_valid), .ctrl_ready(b_ctrl_ready), .ctrl_op(b_ctrl_op),
        .ctrl_tid(b_ctrl_tid), .ctrl_done(b_ctrl_done),
        .self_halt(b_self_halt), .self_halt_tid(b_self_halt_tid),
        .issue_tid(b_issue_tid), .issue_valid(b_issue_valid),
        .issue_restart(b_issue_restart), .running_mask(b_running_mask)
    );

    typedef struct {
        logic [1:0] tid;
        logic       valid;
        logic       restart;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state for the 4-thread build; tests post deltas before each step.
    int         mcnt;
    logic [3:0] mrun, mpend, set_run, clr_run, set_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        if (reset) begin
            e = '{2'd0, 1'b0, 1'b0};
        end else begin
            e.tid     = mcnt[1:0];
            e.valid   = mrun[mcnt];
            e.restart = mrun[mcnt] & mpend[mcnt];
        end
        sb.push_back(e);
        if (reset) begin
            mcnt  = 0;
            mrun  = 4'hF;
            mpend = 4'hF;
        end else begin
            if (e.valid) mpend[mcnt] = 1'b0;
            mrun  = (mrun & ~clr_run) | set_run;
            mpend = mpend | set_pend;
            mcnt  = (mcnt + 1) % 4;
        end
        set_run  = '0;
        clr_run  = '0;
        set_pend = '0;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("issue_tid",     32'(a_issue_tid),     32'(e.tid));
        chk("issue_valid",   32'(a_issue_valid),   32'(e.valid));
        chk("issue_restart", 32'(a_issue_restart), 32'(e.restart));
    endtask

    task automatic wait_done(input bit use_b, input int exp_lat, input string tag);
        int lat = 0;
        bit seen = 1'b0;
        while (!seen && lat < 20) begin
            step();
            lat++;
            if ((use_b ? b_ctrl_done : a_ctrl_done) === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(lat), 32'(exp_lat));
        step();
        chk({tag, "_pulse"}, 32'(use_b ? b_ctrl_done : a_ctrl_done), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected $finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        a_ctrl_valid = 0; a_ctrl_op = 0; a_ctrl_tid = 0; a_self_halt = 0; a_self_halt_tid = 0;
        b_ctrl_valid = 0; b_ctrl_op = 0; b_ctrl_tid = 0; b_self_halt = 0; b_self_halt_tid = 0;
        mcnt = 0; mrun = 4'hF; mpend = 4'hF; set_run = 0; clr_run = 0; set_pend = 0;

        // Reset state
        repeat (3) step();
        chk("rst_ready", 32'(a_ctrl_ready),   32'(0));
        chk("rst_done",  32'(a_ctrl_done),    32'(0));
        chk("rst_mask",  32'(a_running_mask), 32'h0F);
        chk("rst_mask_b", 32'(b_running_mask), 32'h1F);
        reset = 1'b0;

        // T1: round-robin, restart flagged only in the first round
        repeat (8) step();
        chk("idle_ready", 32'(a_ctrl_ready), 32'(1));

        // T2: halt running tid 2
        a_ctrl_valid = 1; a_ctrl_op = 1; a_ctrl_tid = 2; clr_run = 4'b0100;
        step();
        a_ctrl_valid = 0;
        chk("drain_ready", 32'(a_ctrl_ready),   32'(0));
        chk("halt_mask",   32'(a_running_mask), 32'hB);
        wait_done(1'b0, 5, "halt_lat");
        chk("ready_back",  32'(a_ctrl_ready),   32'(1));

        // T3: restart tid 2
        a_ctrl_valid = 1; a_ctrl_op = 0; a_ctrl_tid = 2; set_run = 4'b0100; set_pend = 4'b0100;
        step();
        a_ctrl_valid = 0;
        wait_done(1'b0, 1, "start_lat");
        repeat (4) step();

        // T4: START and self_halt on tid 1 in the same cycle
        a_ctrl_valid = 1; a_ctrl_op = 0; a_ctrl_tid = 1;
        a_self_halt = 1; a_self_halt_tid = 1; set_run = 4'b0010; set_pend = 4'b0010;
        step();
        a_ctrl_valid = 0; a_self_halt = 0;
        chk("conflict_mask", 32'(a_running_mask), 32'hF);
        wait_done(1'b0, 1, "conflict_lat");
        repeat (4) step();

        // Self-halt alone, then HALT on the now-idle thread
        a_self_halt = 1; a_self_halt_tid = 3; clr_run = 4'b1000;
        step();
        a_self_halt = 0;
        chk("self_halt_mask", 32'(a_running_mask), 32'h7);
        chk("self_halt_done", 32'(a_ctrl_done),    32'(0));
        a_ctrl_valid = 1; a_ctrl_op = 1; a_ctrl_tid = 3;
        step();
        a_ctrl_valid = 0;
        wait_done(1'b0, 1, "halt_idle_lat");

        // HALT and self_halt on the same running tid still drain
        a_ctrl_valid = 1; a_ctrl_op = 1; a_ctrl_tid = 0;
        a_self_halt = 1; a_self_halt_tid = 0; clr_run = 4'b0001;
        step();
        a_ctrl_valid = 0; a_self_halt = 0;
        wait_done(1'b0, 5, "halt_self_lat");
        chk("halt_self_mask", 32'(a_running_mask), 32'h6);

        // T5: reset during a drain aborts the command
        a_ctrl_valid = 1; a_ctrl_op = 1; a_ctrl_tid = 2; clr_run = 4'b0100;
        step();
        a_ctrl_valid = 0;
        repeat (2) step();
        reset = 1'b1;
        repeat (2) begin
            step();
            chk("abort_done_rst", 32'(a_ctrl_done), 32'(0));
        end
        reset = 1'b0;
        step();
        chk("abort_mask", 32'(a_running_mask), 32'hF);
        repeat (6) begin
            step();
            chk("abort_no_done", 32'(a_ctrl_done), 32'(0));
        end

        // T6: five-thread wrap and idle-thread halt
        n = 0;
        while (b_issue_tid !== 3'd3 && n < 10) begin
            step();
            n++;
        end
        chk("b_find_tid3", 32'(n < 10), 32'(1));
        step(); chk("b_wrap_4", 32'(b_issue_tid), 32'(4)); chk("b_valid_4", 32'(b_issue_valid), 32'(1));
        step(); chk("b_wrap_0", 32'(b_issue_tid), 32'(0));
        step(); chk("b_wrap_1", 32'(b_issue_tid), 32'(1));
        b_self_halt = 1; b_self_halt_tid = 4;
        step();
        b_self_halt = 0;
        chk("b_self_mask", 32'(b_running_mask), 32'h0F);
        b_ctrl_valid = 1; b_ctrl_op = 1; b_ctrl_tid = 4;
        step();
        b_ctrl_valid = 0;
        wait_done(1'b1, 1, "b_halt_idle_lat");
        b_ctrl_valid = 1; b_ctrl_op = 0; b_ctrl_tid = 6;
        step();
        b_ctrl_valid = 0;
        wait_done(1'b1, 1, "b_bad_tid_lat");
        chk("b_bad_tid_mask", 32'(b_running_mask), 32'h0F);
        b_ctrl_valid = 1; b_ctrl_op = 1; b_ctrl_tid = 1;
        step();
        b_ctrl_valid = 0;
        wait_done(1'b1, 5, "b_halt_lat");
        chk("b_halt_mask", 32'(b_running_mask), 32'h0D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
